alu_result_pipe_mux: RTL and testbench
======================================

Name: alu_result_pipe_mux

Overview:
- Parametrised successor to the ALU's 8:1 structural result multiplexer.
- Selects one of NSRC result buses by ALU index, with slt override.
- Registers the selected result behind a valid/ready handshake with a 2-entry skid buffer, so the multicycle CPU's ALUOut stage can stall without losing results.
- Also produces registered zero and select-error flags.

Parameters:
- WIDTH, 32: width of each source bus and of the result.
- NSRC, 8: number of source buses (index 0..NSRC-1).
- SELW, 3: width of alu_index. Must satisfy 2^SELW >= NSRC.
- SLT_IDX, 1: source slot forced when ifslt=1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; empties the buffer.
- in_valid  input  1  source data and select are valid.
- in_ready  output  1  block can accept this cycle.
- alu_index  input  SELW  source select (LUT ALUindex).
- ifslt  input  1  slt override (LUT ifslt).
- src_data  input  NSRC*WIDTH  flattened sources; slot k = bits [k*WIDTH +: WIDTH].
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts.
- result  output  WIDTH  selected result.
- zero  output  1  result == 0.
- sel_err  output  1  select was out of range.

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on port reset. Both are fixed.
- Select rule (combinational, evaluated at accept):
  - ifslt=1: effective index = SLT_IDX, alu_index ignored.
  - ifslt=0 and alu_index < NSRC: effective index = alu_index.
  - ifslt=0 and alu_index >= NSRC: selected value = 0, err = 1.
  - Otherwise err = 0.
  - zero = (selected value == 0); this includes the error case.
- Accept: in_valid && in_ready at a rising edge. Release: out_valid && out_ready at a rising edge.
- Storage: main register M drives the outputs; skid register S holds one overflow entry. Each entry is {value, zero, err}.
- State machine:
  - EMPTY: accept without release → ONE (M gets input).
  - ONE:
    - Accept with release → ONE (M gets input).
    - Accept without release → TWO (S gets input).
    - Release without accept → EMPTY.
    - Neither → ONE.
  - TWO: in_ready=0.
    - Release → ONE (M gets S).
    - No release → TWO, hold.
- Ready and valid: in_ready = (state != TWO) && !reset. out_valid = (state != EMPTY).
- Latency: 1 cycle. Data accepted at edge N appears on result at edge N when the buffer was empty or releasing.
- Throughput: 1 result/cycle with out_ready held at 1.
- Hold: when out_valid=1 and out_ready=0, result, zero and sel_err stay stable until release.
- Flush: at the edge, state → EMPTY and any simultaneous accept is dropped. Flush has priority over accept and release. M and S contents are don't-care afterwards, but outputs read 0 (see below).
- Reset, at any time including mid-transfer: state=EMPTY, out_valid=0, result=0, zero=0, sel_err=0, M and S cleared.
- Outputs when EMPTY: result, zero and sel_err are forced to 0.
- Ordering: strict FIFO. No entry is ever dropped except by flush or reset.

Optional Feature:
- Macro: ALU_RESULT_PIPE_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit) = XOR reduction of result, stored per entry alongside zero.
  - Reset value 0; forced to 0 when EMPTY; held stable under stall like the other outputs.
- Undefined: the port and its storage are absent. All other behaviour is identical.

Test Plan:
- Reset mid-stream: state TWO, assert reset asynchronously between edges → out_valid=0, result=0, zero=0, sel_err=0 immediately. in_ready=0 while reset is high, and 1 after release.
- Select sweep, NSRC=8, out_ready=1: src slot k = 32'h1000_0000+k. Accept alu_index 0..7 with ifslt=0 → result 32'h1000_0000..32'h1000_0007 on consecutive cycles. Repeat with ifslt=1 → every result = 32'h1000_0001.
- Out-of-range select: NSRC=5, SELW=3, alu_index=6, ifslt=0 → result=0, zero=1, sel_err=1. Next accept with alu_index=2 → sel_err=0.
- Backpressure: out_ready=0, accept A=32'hA, then B=32'hB → in_ready=0, result holds 32'hA. Raise out_ready for 2 cycles → A then B released, in_ready returns to 1, order preserved.
- Flush priority: state ONE holding 32'h5, assert flush with in_valid=1 and data 32'h7 → next cycle out_valid=0, result=0. The value 32'h7 is never output.
- Zero flag and parity (with ALU_RESULT_PIPE_PARITY_EN defined): selected 0 → zero=1, parity=0. Selected 32'h0000_0007 → zero=0, parity=1.

Source files
------------

// File: rtl/alu_result_pipe_mux.sv
// ALU result selector registered behind a valid/ready handshake with a 2-entry skid buffer.
// Optional per-entry parity output is enabled with ALU_RESULT_PIPE_PARITY_EN.
module alu_result_pipe_mux #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 8,
    parameter int SELW    = 3,
    parameter int SLT_IDX = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       alu_index,
    input  logic                  ifslt,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  zero,
`ifdef ALU_RESULT_PIPE_PARITY_EN
    output logic                  parity,
`endif
    output logic                  sel_err
);

    // Handshake: a word moves on any rising edge where valid and ready are both high;
    // the producer holds data while valid && !ready, the consumer sees stable data likewise.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             zero;
`ifdef ALU_RESULT_PIPE_PARITY_EN
        logic             parity;
`endif
        logic             err;
    } entry_t;

    state_t           state;
    entry_t           m_entry;
    entry_t           s_entry;
    entry_t           in_entry;
    logic [WIDTH-1:0] sel_value;
    logic             sel_bad;
    logic             accept;
    logic             release_w;

    always_comb begin
        sel_value = '0;
        sel_bad   = 1'b0;
        if (ifslt) begin
            sel_value = src_data[SLT_IDX*WIDTH +: WIDTH];
        end else if (int'(alu_index) < NSRC) begin
            for (int k = 0; k < NSRC; k++) begin
                if (int'(alu_index) == k) sel_value = src_data[k*WIDTH +: WIDTH];
            end
        end else begin
            sel_bad = 1'b1;
        end
    end

    always_comb begin
        in_entry       = '0;
        in_entry.value = sel_value;
        in_entry.zero  = (sel_value == '0);
`ifdef ALU_RESULT_PIPE_PARITY_EN
        in_entry.parity = ^sel_value;
`endif
        in_entry.err   = sel_bad;
    end

    assign in_ready  = (state != TWO) && !reset;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign release_w = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            m_entry <= '0;
            s_entry <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_entry <= in_entry;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && release_w) begin
                        m_entry <= in_entry;
                    end else if (accept) begin
                        s_entry <= in_entry;
                        state   <= TWO;
                    end else if (release_w) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (release_w) begin
                        m_entry <= s_entry;
                        state   <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Outputs read as zero whenever nothing is buffered, whatever M holds.
    assign result  = out_valid ? m_entry.value : '0;
    assign zero    = out_valid ? m_entry.zero  : 1'b0;
    assign sel_err = out_valid ? m_entry.err   : 1'b0;
`ifdef ALU_RESULT_PIPE_PARITY_EN
    assign parity  = out_valid ? m_entry.parity : 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_pipe_mux.sv
// Self-checking bench for alu_result_pipe_mux: directed vectors, corner sequences and a
// randomized run against a queue-based reference model.
module tb_alu_result_pipe_mux;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_index;
    logic         ifslt;
    logic [8*W-1:0] src_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         sel_err;

    logic         in_valid5;
    logic         in_ready5;
    logic [2:0]   alu_index5;
    logic         out_valid5;
    logic [W-1:0] result5;
    logic         zero5;
    logic         sel_err5;
    logic [5*W-1:0] src_data5;
`ifdef ALU_RESULT_PIPE_PARITY_EN
    logic         parity;
    logic         parity5;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [W+1:0] exp_q[$];   // {value, zero, err}

    typedef struct {
        logic [2:0]   idx;
        logic         slt;
        logic [W-1:0] exp_result;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    alu_result_pipe_mux #(.WIDTH(W), .NSRC(8), .SELW(3), .SLT_IDX(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_index(alu_index), .ifslt(ifslt), .src_data(src_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero),
`ifdef ALU_RESULT_PIPE_PARITY_EN
        .parity(parity),
`endif
        .sel_err(sel_err)
    );

    alu_result_pipe_mux #(.WIDTH(W), .NSRC(5), .SELW(3), .SLT_IDX(1)) dut5 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid5), .in_ready(in_ready5),
        .alu_index(alu_index5), .ifslt(1'b0), .src_data(src_data5), .out_valid(out_valid5),
        .out_ready(1'b1), .result(result5), .zero(zero5),
`ifdef ALU_RESULT_PIPE_PARITY_EN
        .parity(parity5),
`endif
        .sel_err(sel_err5)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [W-1:0] v);
        src_data[k*W +: W] = v;
    endtask

    function automatic logic [W-1:0] ref_select(input logic [8*W-1:0] src, input logic [2:0] idx,
                                                input logic slt);
        if (slt) return src[1*W +: W];
        return src[int'(idx)*W +: W];
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_index = '0; ifslt = 1'b0;
        out_ready = 1'b1; in_valid5 = 1'b0; alu_index5 = '0;
        for (int k = 0; k < 8; k++) set_slot(k, 32'h1000_0000 + k);
        for (int k = 0; k < 5; k++) src_data5[k*W +: W] = 32'h1000_0000 + k;
        for (int i = 0; i < 16; i++) begin
            vecs[i].idx = 3'(i % 8);
            vecs[i].slt = (i >= 8);
            vecs[i].exp_result = (i >= 8) ? 32'h1000_0001 : 32'h1000_0000 + (i % 8);
        end

        // Reset state
        #1;
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_in_ready", W'(in_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rel_in_ready", W'(in_ready), 1);

        // Select sweep: one result per cycle
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; alu_index = vecs[i].idx; ifslt = vecs[i].slt;
            tick();
            chk($sformatf("sweep%0d_result", i), result, vecs[i].exp_result);
            chk($sformatf("sweep%0d_valid", i), W'(out_valid), 1);
            chk($sformatf("sweep%0d_zero", i), W'(zero), 0);
            chk($sformatf("sweep%0d_err", i), W'(sel_err), 0);
        end
        in_valid = 1'b0; ifslt = 1'b0;
        tick();
        chk("sweep_drain_valid", W'(out_valid), 0);
        chk("sweep_drain_result", result, 0);

        // Zero flag and parity
        set_slot(0, 32'h0); alu_index = 3'd0; in_valid = 1'b1;
        tick();
        chk("zero_sel0_zero", W'(zero), 1);
        chk("zero_sel0_result", result, 0);
`ifdef ALU_RESULT_PIPE_PARITY_EN
        chk("zero_sel0_parity", W'(parity), 0);
`endif
        set_slot(0, 32'h7);
        tick();
        chk("zero_sel7_zero", W'(zero), 0);
        chk("zero_sel7_result", result, 32'h7);
`ifdef ALU_RESULT_PIPE_PARITY_EN
        chk("zero_sel7_parity", W'(parity), 1);
`endif
        in_valid = 1'b0;
        tick();

        // Out-of-range select on the 5-source instance
        in_valid5 = 1'b1; alu_index5 = 3'd6;
        tick();
        chk("oor_valid", W'(out_valid5), 1);
        chk("oor_result", result5, 0);
        chk("oor_zero", W'(zero5), 1);
        chk("oor_err", W'(sel_err5), 1);
        alu_index5 = 3'd2;
        tick();
        chk("inr_result", result5, 32'h1000_0002);
        chk("inr_err", W'(sel_err5), 0);
        chk("inr_zero", W'(zero5), 0);
        in_valid5 = 1'b0;
        tick();
        chk("inr_drain", W'(out_valid5), 0);

        // Backpressure: A then B held, released in order
        out_ready = 1'b0; set_slot(0, 32'hA); alu_index = 3'd0; in_valid = 1'b1;
        tick();
        chk("bp_a_result", result, 32'hA);
        chk("bp_a_in_ready", W'(in_ready), 1);
        set_slot(0, 32'hB);
        tick();
        chk("bp_b_in_ready", W'(in_ready), 0);
        chk("bp_b_hold", result, 32'hA);
        in_valid = 1'b0;
        tick();
        chk("bp_stall_hold", result, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_rel1_result", result, 32'hB);
        chk("bp_rel1_in_ready", W'(in_ready), 1);
        tick();
        chk("bp_rel2_valid", W'(out_valid), 0);

        // Flush priority over a simultaneous accept
        out_ready = 1'b0; set_slot(0, 32'h5); in_valid = 1'b1;
        tick();
        chk("fl_hold5", result, 32'h5);
        set_slot(0, 32'h7); flush = 1'b1;
        tick();
        chk("fl_valid", W'(out_valid), 0);
        chk("fl_result", result, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_no7_valid", W'(out_valid), 0);
        chk("fl_no7_result", result, 0);

        // Asynchronous reset mid-stream from a full buffer
        set_slot(0, 32'h33); in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("mid_full_in_ready", W'(in_ready), 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", W'(out_valid), 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", W'(zero), 0);
        chk("mid_rst_err", W'(sel_err), 0);
        chk("mid_rst_in_ready", W'(in_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rel_in_ready", W'(in_ready), 1);
        chk("mid_rel_valid", W'(out_valid), 0);

        // Randomized traffic against the queue model
        exp_q.delete();
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic         acc;
            logic         rel;
            logic [W+1:0] e;
            logic [W-1:0] v;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            ifslt     = ($urandom_range(0, 5) == 0);
            alu_index = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++)
                set_slot(k, ($urandom_range(0, 7) == 0) ? 32'h0 : W'($urandom));
            #2;
            chk("rnd_in_ready", W'(in_ready), W'(exp_q.size() < 2));
            chk("rnd_out_valid", W'(out_valid), W'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rnd_result", result, e[W+1:2]);
                chk("rnd_zero", W'(zero), W'(e[1]));
                chk("rnd_err", W'(sel_err), W'(e[0]));
`ifdef ALU_RESULT_PIPE_PARITY_EN
                chk("rnd_parity", W'(parity), W'(^e[W+1:2]));
`endif
            end else begin
                chk("rnd_empty_result", result, 0);
            end
            acc = in_valid && (exp_q.size() < 2);
            rel = out_ready && (exp_q.size() > 0);
            v   = ref_select(src_data, alu_index, ifslt);
            @(posedge clk);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (rel) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({v, (v == 0), 1'b0});
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
